hazard_stall_ctrl: RTL

//  Pipeline hazard and stall controller for the 5-stage RV32I core. Sits next to the

---
 rtl/hazard_stall_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: RV32I 5-stage hazard unit with forwarding, load-use/branch control, memory-wait freeze, timeout trap and stall counter
// Ports: clk/rst_n (async active-low); Rs*/Rd* stage register addresses; ResultSrcE, RegWriteM/W, PcSrcE;
//        dmem_req/dmem_ready memory handshake; ForwardAE/BE forwarding selects; Stall*/Flush* stage enables;
//        mem_err sticky timeout flag; stall_cnt saturating count of StallF cycles.
module hazard_stall_ctrl #(
    parameter int RA_W    = 5,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RA_W-1:0]  Rs1D,
    input  logic [RA_W-1:0]  Rs2D,
    input  logic [RA_W-1:0]  Rs1E,
    input  logic [RA_W-1:0]  Rs2E,
    input  logic [RA_W-1:0]  RdE,
    input  logic [RA_W-1:0]  RdM,
    input  logic [RA_W-1:0]  RdW,
    input  logic [1:0]       ResultSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PcSrcE,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int WC_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              lw_stall, mem_busy;

    always_comb begin
        ForwardAE = (RegWriteM && RdM != '0 && RdM == Rs1E) ? 2'b10 :
                    (RegWriteW && RdW != '0 && RdW == Rs1E) ? 2'b01 : 2'b00;
        ForwardBE = (RegWriteM && RdM != '0 && RdM == Rs2E) ? 2'b10 :
                    (RegWriteW && RdW != '0 && RdW == Rs2E) ? 2'b01 : 2'b00;
    end

    assign lw_stall = (ResultSrcE == 2'b01) && RdE != '0 && (RdE == Rs1D || RdE == Rs2D);
    assign mem_busy = (state_q == ERR) || (dmem_req && !dmem_ready);

    // A memory freeze holds E, so a pending branch or load-use simply re-presents once it lifts.
    always_comb begin
        StallF = mem_busy || (!PcSrcE && lw_stall);
        StallD = StallF;
        StallE = mem_busy;
        StallM = mem_busy;
        FlushW = mem_busy;
        FlushD = !mem_busy && PcSrcE;
        FlushE = !mem_busy && (PcSrcE || lw_stall);
    end

    // wait_cnt counts consecutive not-ready cycles; the cycle that enters WAIT is the first.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: if (dmem_req && !dmem_ready) begin
                state_d    = WAIT;
                wait_cnt_d = WC_W'(1);
            end
            WAIT: if (!dmem_req || dmem_ready) begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end else begin
                wait_cnt_d = wait_cnt_q + WC_W'(1);
                state_d    = (wait_cnt_q == WC_W'(TIMEOUT - 1)) ? ERR : WAIT;
            end
            default: state_d = ERR;
        endcase
        stall_cnt_d = (StallF && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_err   = (state_q == ERR);
    assign stall_cnt = stall_cnt_q;
endmodule
